tx_arbiter: RTL and testbench

//  Shares the single TX serializer between the scheduler (data/address accesses, via the decoder)
//  and the instruction prefetcher. Grants one command at a time, holds the grant until tx_done,

---
 rtl/tx_arbiter_pkg.sv | 16 +
 rtl/tx_arbiter_reply_tag_fifo.sv | 67 ++++++
 rtl/tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_tx_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arbiter_pkg.sv
// Shared types and constants for the TX arbiter slice.
// Owner tags identify which requester issued a TX command.
package tx_arbiter_pkg;

    localparam int TX_CMD_BITS = 8;

    localparam logic TX_OWNER_SC = 1'b0;
    localparam logic TX_OWNER_PF = 1'b1;

    typedef enum logic [1:0] {
        TX_ARB_IDLE = 2'd0,
        TX_ARB_SC   = 2'd1,
        TX_ARB_PF   = 2'd2
    } tx_arb_state_e;

endpackage

// File: rtl/tx_arbiter_reply_tag_fifo.sv
// In-order FIFO of 1-bit owner tags for commands awaiting a reply.
// Simultaneous push and pop is legal even when full.
module tx_arbiter_reply_tag_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_tag,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_tag;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Register FIFO state; reset empties it.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Arbitrates the TX serializer between scheduler and prefetcher,
// and steers each RX reply back to the requester that asked for it.
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int NSHIFT   = 2,
    parameter int CMD_BITS = TX_CMD_BITS,
    parameter int MAX_OUT  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sc_cmd_valid,
    input  logic [CMD_BITS-1:0] sc_cmd,
    input  logic                sc_reply_wanted,
    input  logic                sc_reserve,
    input  logic [NSHIFT-1:0]   sc_data,
    output logic                sc_cmd_started,
    output logic                sc_data_next,
    input  logic                pf_cmd_valid,
    input  logic [CMD_BITS-1:0] pf_cmd,
    input  logic                pf_reply_wanted,
    input  logic [NSHIFT-1:0]   pf_data,
    output logic                pf_cmd_started,
    output logic                pf_data_next,
    output logic                tx_command_valid,
    output logic [CMD_BITS-1:0] tx_command,
    output logic                tx_reply_wanted,
    output logic [NSHIFT-1:0]   tx_data,
    input  logic                tx_command_started,
    input  logic                tx_data_next,
    input  logic                tx_done,
    input  logic                rx_started,
    input  logic                rx_done,
    output logic                rx_to_sc,
    output logic                rx_to_pf,
    output logic                reply_overflow_err
);

    tx_arb_state_e state_q, state_d;
    logic          rx_busy_q, rx_busy_d;
    logic          rx_owner_q, rx_owner_d;
    logic          err_q, err_d;

    logic          fifo_push;
    logic          fifo_tag;
    logic          fifo_pop;
    logic          fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          sc_pick;
    logic          pf_pick;
    logic          grant_ok;
    logic          rx_owner_now;
    logic          rx_active;

    tx_arbiter_reply_tag_fifo #(
        .DEPTH (MAX_OUT)
    ) u_tags (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_tag (fifo_tag),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Grant selection, payload muxing and FSM next state.
    always_comb begin
        state_d          = state_q;
        sc_cmd_started   = 1'b0;
        pf_cmd_started   = 1'b0;
        sc_data_next     = 1'b0;
        pf_data_next     = 1'b0;
        tx_command_valid = 1'b0;
        tx_command       = '0;
        tx_reply_wanted  = 1'b0;
        tx_data          = '0;
        fifo_push        = 1'b0;
        fifo_tag         = TX_OWNER_SC;
        grant_ok         = 1'b0;
        sc_pick          = sc_cmd_valid;
        pf_pick          = pf_cmd_valid && !sc_cmd_valid && !sc_reserve;
        unique case (state_q)
            TX_ARB_IDLE: begin
                if (sc_pick) begin
                    tx_command      = sc_cmd;
                    tx_reply_wanted = sc_reply_wanted;
                    grant_ok        = !(sc_reply_wanted && fifo_full);
                end else if (pf_pick) begin
                    tx_command      = pf_cmd;
                    tx_reply_wanted = pf_reply_wanted;
                    grant_ok        = !(pf_reply_wanted && fifo_full);
                end
                tx_command_valid = grant_ok;
                if (grant_ok && tx_command_started) begin
                    fifo_push      = tx_reply_wanted;
                    fifo_tag       = sc_pick ? TX_OWNER_SC : TX_OWNER_PF;
                    sc_cmd_started = sc_pick;
                    pf_cmd_started = !sc_pick;
                    state_d        = sc_pick ? TX_ARB_SC : TX_ARB_PF;
                end
            end
            TX_ARB_SC: begin
                tx_command      = sc_cmd;
                tx_reply_wanted = sc_reply_wanted;
                tx_data         = sc_data;
                sc_data_next    = tx_data_next;
                if (tx_done) begin
                    state_d = TX_ARB_IDLE;
                end
            end
            TX_ARB_PF: begin
                tx_command      = pf_cmd;
                tx_reply_wanted = pf_reply_wanted;
                tx_data         = pf_data;
                pf_data_next    = tx_data_next;
                if (tx_done) begin
                    state_d = TX_ARB_IDLE;
                end
            end
            default: begin
                state_d = TX_ARB_IDLE;
            end
        endcase
    end

    // Reply steering: head tag is used directly in the rx_started cycle.
    always_comb begin
        fifo_pop     = rx_started && !fifo_empty;
        rx_busy_d    = rx_busy_q;
        rx_owner_d   = rx_owner_q;
        err_d        = err_q || (rx_started && fifo_empty);
        rx_active    = rx_busy_q;
        rx_owner_now = rx_owner_q;
        if (rx_started) begin
            rx_active    = !fifo_empty;
            rx_owner_now = fifo_head;
            rx_busy_d    = !fifo_empty && !rx_done;
            rx_owner_d   = fifo_head;
        end else if (rx_done) begin
            rx_busy_d = 1'b0;
        end
        rx_to_sc           = rx_active && (rx_owner_now == TX_OWNER_SC);
        rx_to_pf           = rx_active && (rx_owner_now == TX_OWNER_PF);
        reply_overflow_err = err_q;
    end

    // State, reply owner and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= TX_ARB_IDLE;
            rx_busy_q  <= 1'b0;
            rx_owner_q <= TX_OWNER_SC;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_busy_q  <= rx_busy_d;
            rx_owner_q <= rx_owner_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed self-checking bench for tx_arbiter.
// Inputs change 1ns after posedge; outputs are checked before the next edge.
module tb_tx_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       sc_cmd_valid, sc_reply_wanted, sc_reserve;
    logic [7:0] sc_cmd;
    logic [1:0] sc_data;
    logic       sc_cmd_started, sc_data_next;
    logic       pf_cmd_valid, pf_reply_wanted;
    logic [7:0] pf_cmd;
    logic [1:0] pf_data;
    logic       pf_cmd_started, pf_data_next;
    logic       tx_command_valid, tx_reply_wanted;
    logic [7:0] tx_command;
    logic [1:0] tx_data;
    logic       tx_command_started, tx_data_next, tx_done;
    logic       rx_started, rx_done;
    logic       rx_to_sc, rx_to_pf, reply_overflow_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tx_arbiter #(
        .NSHIFT   (2),
        .CMD_BITS (8),
        .MAX_OUT  (2)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .sc_cmd_valid       (sc_cmd_valid),
        .sc_cmd             (sc_cmd),
        .sc_reply_wanted    (sc_reply_wanted),
        .sc_reserve         (sc_reserve),
        .sc_data            (sc_data),
        .sc_cmd_started     (sc_cmd_started),
        .sc_data_next       (sc_data_next),
        .pf_cmd_valid       (pf_cmd_valid),
        .pf_cmd             (pf_cmd),
        .pf_reply_wanted    (pf_reply_wanted),
        .pf_data            (pf_data),
        .pf_cmd_started     (pf_cmd_started),
        .pf_data_next       (pf_data_next),
        .tx_command_valid   (tx_command_valid),
        .tx_command         (tx_command),
        .tx_reply_wanted    (tx_reply_wanted),
        .tx_data            (tx_data),
        .tx_command_started (tx_command_started),
        .tx_data_next       (tx_data_next),
        .tx_done            (tx_done),
        .rx_started         (rx_started),
        .rx_done            (rx_done),
        .rx_to_sc           (rx_to_sc),
        .rx_to_pf           (rx_to_pf),
        .reply_overflow_err (reply_overflow_err)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        sc_cmd_valid = 0; sc_cmd = 0; sc_reply_wanted = 0;
        sc_reserve = 0; sc_data = 0;
        pf_cmd_valid = 0; pf_cmd = 0; pf_reply_wanted = 0; pf_data = 0;
        tx_command_started = 0; tx_data_next = 0; tx_done = 0;
        rx_started = 0; rx_done = 0;
        step();
        step();
        reset = 1'b0;
        settle();
        check("rst_valid", 32'(tx_command_valid), 0);
        check("rst_cmd", 32'(tx_command), 0);
        check("rst_rx_sc", 32'(rx_to_sc), 0);
        check("rst_rx_pf", 32'(rx_to_pf), 0);
        check("rst_err", 32'(reply_overflow_err), 0);

        // 1: prefetcher alone, reply wanted
        pf_cmd_valid = 1; pf_cmd = 8'h01; pf_reply_wanted = 1;
        settle();
        check("t1_valid", 32'(tx_command_valid), 1);
        check("t1_cmd", 32'(tx_command), 32'h01);
        check("t1_rw", 32'(tx_reply_wanted), 1);
        tx_command_started = 1;
        settle();
        check("t1_pf_started", 32'(pf_cmd_started), 1);
        check("t1_sc_started", 32'(sc_cmd_started), 0);
        step();
        tx_command_started = 0; pf_cmd_valid = 0;
        pf_data = 2'b10; sc_data = 2'b01; tx_data_next = 1;
        settle();
        check("t1_tx_valid0", 32'(tx_command_valid), 0);
        check("t1_pulse_end", 32'(pf_cmd_started), 0);
        check("t1_tx_data", 32'(tx_data), 2);
        check("t1_pf_next", 32'(pf_data_next), 1);
        check("t1_sc_next", 32'(sc_data_next), 0);
        tx_done = 1;
        step();
        tx_done = 0; tx_data_next = 0;

        // 2: both request, scheduler wins
        sc_cmd_valid = 1; sc_cmd = 8'hA5; sc_reply_wanted = 1;
        pf_cmd_valid = 1; pf_cmd = 8'h3C; pf_reply_wanted = 1;
        settle();
        check("t2_valid", 32'(tx_command_valid), 1);
        check("t2_cmd", 32'(tx_command), 32'hA5);
        tx_command_started = 1;
        settle();
        check("t2_sc_started", 32'(sc_cmd_started), 1);
        check("t2_pf_started", 32'(pf_cmd_started), 0);
        step();
        tx_command_started = 0; sc_cmd_valid = 0; tx_data_next = 1;
        settle();
        check("t2_sc_tx_data", 32'(tx_data), 1);
        check("t2_sc_next", 32'(sc_data_next), 1);
        check("t2_pf_next", 32'(pf_data_next), 0);
        tx_done = 1;
        settle();
        check("t2_done_nogrant", 32'(tx_command_valid), 0);
        step();
        tx_done = 0; tx_data_next = 0;

        // 5: FIFO holds [PF,SC] and is full, pf reply request held off
        settle();
        check("t5_full_hold", 32'(tx_command_valid), 0);
        pf_reply_wanted = 0;
        settle();
        check("t5_noreply_ok", 32'(tx_command_valid), 1);
        pf_reply_wanted = 1;
        rx_started = 1;
        settle();
        check("t4_rx1_pf", 32'(rx_to_pf), 1);
        check("t4_rx1_sc", 32'(rx_to_sc), 0);
        step();
        rx_started = 0;
        settle();
        check("t4_rx1_hold", 32'(rx_to_pf), 1);
        check("t2_pf_grant", 32'(tx_command_valid), 1);
        check("t2_pf_cmd", 32'(tx_command), 32'h3C);
        rx_done = 1; tx_command_started = 1;
        settle();
        check("t2_pf_started", 32'(pf_cmd_started), 1);
        check("t4_rx1_last", 32'(rx_to_pf), 1);
        step();
        rx_done = 0; tx_command_started = 0; pf_cmd_valid = 0;
        settle();
        check("t4_rx1_clear", 32'(rx_to_pf), 0);
        tx_done = 1;
        step();
        tx_done = 0;
        // FIFO [SC,PF]: single-cycle reply goes to scheduler
        rx_started = 1; rx_done = 1;
        settle();
        check("t4_rx2_sc", 32'(rx_to_sc), 1);
        check("t4_rx2_pf", 32'(rx_to_pf), 0);
        step();
        rx_started = 0; rx_done = 0;
        settle();
        check("t4_rx2_clear", 32'(rx_to_sc), 0);

        // 5: push and pop in the same cycle, FIFO [PF] -> [SC]
        sc_cmd_valid = 1; sc_cmd = 8'h11; sc_reply_wanted = 1;
        tx_command_started = 1; rx_started = 1;
        settle();
        check("t5_pp_started", 32'(sc_cmd_started), 1);
        check("t5_pp_rx_pf", 32'(rx_to_pf), 1);
        step();
        sc_cmd_valid = 0; tx_command_started = 0; rx_started = 0;
        settle();
        check("t5_pp_rx_hold", 32'(rx_to_pf), 1);
        rx_done = 1; tx_done = 1;
        step();
        rx_done = 0; tx_done = 0;
        pf_cmd_valid = 1; pf_cmd = 8'h55; pf_reply_wanted = 1;
        settle();
        check("t5_count1", 32'(tx_command_valid), 1);
        rx_started = 1; rx_done = 1;
        settle();
        check("t5_rx_sc", 32'(rx_to_sc), 1);
        step();
        rx_started = 0; rx_done = 0;

        // 3: reserve blocks prefetcher
        pf_cmd = 8'h77; pf_reply_wanted = 0; sc_reserve = 1;
        settle();
        check("t3_res_block", 32'(tx_command_valid), 0);
        step();
        check("t3_res_block2", 32'(tx_command_valid), 0);
        sc_reserve = 0;
        settle();
        check("t3_res_drop", 32'(tx_command_valid), 1);
        check("t3_res_cmd", 32'(tx_command), 32'h77);

        // 6: reply with empty FIFO
        rx_started = 1; rx_done = 1;
        settle();
        check("t6_rx_sc", 32'(rx_to_sc), 0);
        check("t6_rx_pf", 32'(rx_to_pf), 0);
        step();
        rx_started = 0; rx_done = 0;
        settle();
        check("t6_err", 32'(reply_overflow_err), 1);
        step();
        check("t6_err_sticky", 32'(reply_overflow_err), 1);
        tx_command_started = 1;
        step();
        tx_command_started = 0; pf_data = 2'b11; tx_data_next = 1;
        settle();
        check("t6_in_pf_tx", 32'(tx_data), 3);
        reset = 1;
        step();
        reset = 0;
        settle();
        check("t6_rst_err", 32'(reply_overflow_err), 0);
        check("t6_rst_idle", 32'(tx_command_valid), 1);
        check("t6_rst_data", 32'(tx_data), 0);
        check("t6_rst_next", 32'(pf_data_next), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
